// File: rtl/core_step_fsm.sv
// -----------------------------------------------------------------------------
// core_step_fsm
//
// Purpose:
//   Sequencing controller for a single-issue, non-pipelined core. It steps one
//   instruction at a time through fetch, execute, optional data-memory access
//   and write-back. It also keeps the architectural PC, the registered
//   instruction and the retired-instruction counter. A stalled handshake
//   that exceeds TIMEOUT cycles halts the core. A misaligned next PC or an
//   ebreak also halts the core.
//
// Parameters:
//   XLEN      width of pc, exec_next_pc and instret
//   RESET_PC  pc value loaded by reset
//   TIMEOUT   maximum cycles spent in any REQ or WAIT state before abort
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   ifetch_req_valid   out  fetch request (held until ifetch_req_ready)
//   ifetch_req_ready   in   fetch request accepted
//   ifetch_addr        out  fetch address (always equals pc)
//   ifetch_rsp_valid   in   fetch data valid (only honoured in FETCH_WAIT)
//   ifetch_rsp_data    in   fetched instruction word
//   instr              out  registered instruction for decoder/datapath
//   pc                 out  architectural PC
//   dec_is_mem         in   instr needs a data-memory access
//   dec_is_ebreak      in   instr is ebreak
//   exec_wb_en         in   instr writes the register file
//   exec_next_pc       in   next PC from the datapath next-PC mux
//   dmem_req_valid     out  data request (held until dmem_req_ready)
//   dmem_req_ready     in   data request accepted
//   dmem_rsp_valid     in   data response valid (only honoured in MEM_WAIT)
//   reg_we             out  register-file write enable, one-cycle pulse in WB
//   commit             out  retire pulse
//   instret            out  retired-instruction count (wraps)
//   halted             out  core is in HALT
//   halt_code          out  0 running, 1 ebreak, 2 misaligned PC, 3 timeout
// -----------------------------------------------------------------------------
module core_step_fsm #(
    parameter int unsigned       XLEN     = 64,
    parameter logic [XLEN-1:0]   RESET_PC = XLEN'(64'h8000_0000),
    parameter int unsigned       TIMEOUT  = 256
) (
    input  logic            clk,
    input  logic            rst,

    output logic            ifetch_req_valid,
    input  logic            ifetch_req_ready,
    output logic [XLEN-1:0] ifetch_addr,
    input  logic            ifetch_rsp_valid,
    input  logic [31:0]     ifetch_rsp_data,

    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc,

    input  logic            dec_is_mem,
    input  logic            dec_is_ebreak,
    input  logic            exec_wb_en,
    input  logic [XLEN-1:0] exec_next_pc,

    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    input  logic            dmem_rsp_valid,

    output logic            reg_we,
    output logic            commit,
    output logic [XLEN-1:0] instret,
    output logic            halted,
    output logic [1:0]      halt_code
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] HALT_NONE    = 2'd0;
    localparam logic [1:0] HALT_EBREAK  = 2'd1;
    localparam logic [1:0] HALT_MISALIGN = 2'd2;
    localparam logic [1:0] HALT_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        FETCH_REQ  = 3'd0,
        FETCH_WAIT = 3'd1,
        EXEC       = 3'd2,
        MEM_REQ    = 3'd3,
        MEM_WAIT   = 3'd4,
        WB         = 3'd5,
        HALT       = 3'd6
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             wait_expired;
    logic             counting_state;
    logic             load_instr;
    logic             retire;
    logic             load_pc;
    logic [1:0]       halt_code_next;

    // Only the handshake states are bounded by the timeout; the counter stays
    // put everywhere else so it can never wrap in HALT.
    assign counting_state = (state == FETCH_REQ) || (state == FETCH_WAIT) ||
                            (state == MEM_REQ)   || (state == MEM_WAIT);
    assign wait_expired   = (wait_cnt == CNT_W'(TIMEOUT - 1));

    // -------------------------------------------------------------------------
    // Next-state and per-cycle control
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_next     = state;
        load_instr     = 1'b0;
        retire         = 1'b0;
        load_pc        = 1'b0;
        halt_code_next = halt_code;

        case (state)
            FETCH_REQ: begin
                if (ifetch_req_ready) begin
                    state_next = FETCH_WAIT;
                end else if (wait_expired) begin
                    state_next     = HALT;
                    halt_code_next = HALT_TIMEOUT;
                end
            end

            FETCH_WAIT: begin
                if (ifetch_rsp_valid) begin
                    load_instr = 1'b1;
                    state_next = EXEC;
                end else if (wait_expired) begin
                    state_next     = HALT;
                    halt_code_next = HALT_TIMEOUT;
                end
            end

            EXEC: begin
                // ebreak wins over a memory access: it retires here and never
                // touches the data port.
                if (dec_is_ebreak) begin
                    retire         = 1'b1;
                    state_next     = HALT;
                    halt_code_next = HALT_EBREAK;
                end else if (dec_is_mem) begin
                    state_next = MEM_REQ;
                end else begin
                    state_next = WB;
                end
            end

            MEM_REQ: begin
                if (dmem_req_ready) begin
                    state_next = MEM_WAIT;
                end else if (wait_expired) begin
                    state_next     = HALT;
                    halt_code_next = HALT_TIMEOUT;
                end
            end

            MEM_WAIT: begin
                if (dmem_rsp_valid) begin
                    state_next = WB;
                end else if (wait_expired) begin
                    state_next     = HALT;
                    halt_code_next = HALT_TIMEOUT;
                end
            end

            WB: begin
                // The instruction retires and pc is loaded even when the new
                // pc is misaligned; the halt happens afterwards.
                retire  = 1'b1;
                load_pc = 1'b1;
                if (exec_next_pc[1:0] != 2'b00) begin
                    state_next     = HALT;
                    halt_code_next = HALT_MISALIGN;
                end else begin
                    state_next = FETCH_REQ;
                end
            end

            HALT: begin
                state_next = HALT;
            end

            default: begin
                state_next = FETCH_REQ;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and architectural registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (rst) begin
            state     <= FETCH_REQ;
            pc        <= RESET_PC;
            instr     <= '0;
            instret   <= '0;
            halt_code <= HALT_NONE;
            wait_cnt  <= '0;
        end else begin
            state     <= state_next;
            halt_code <= halt_code_next;

            if (load_instr) begin
                instr <= ifetch_rsp_data;
            end
            if (load_pc) begin
                pc <= exec_next_pc;
            end
            if (retire) begin
                instret <= instret + XLEN'(1);
            end

            if (state_next != state) begin
                wait_cnt <= '0;
            end else if (counting_state) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Request valids and pulses are masked while rst is high so nothing is
    // issued or retired in the reset cycle, whatever state is being left.
    assign ifetch_req_valid = !rst && (state == FETCH_REQ);
    assign dmem_req_valid   = !rst && (state == MEM_REQ);
    assign reg_we           = !rst && (state == WB) && exec_wb_en;
    assign commit           = !rst && retire;
    assign ifetch_addr      = pc;
    assign halted           = (state == HALT);

endmodule

// File: tb/tb_core_step_fsm.sv
// -----------------------------------------------------------------------------
// tb_core_step_fsm
//
// Directed bench for core_step_fsm. One linear sequence drives the memory
// and decoder side by hand and checks outputs 1-2 ns after each rising edge.
// Scenarios: reset state, a zero-wait ALU op, a load with a stalled data
// port, a misaligned jump, an ebreak, reset during MEM_WAIT with a late
// response, and a fetch timeout.
// -----------------------------------------------------------------------------
module tb_core_step_fsm;

    localparam int unsigned XLEN     = 64;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;
    localparam int unsigned TIMEOUT  = 256;

    logic            clk;
    logic            rst;
    logic            ifetch_req_valid;
    logic            ifetch_req_ready;
    logic [XLEN-1:0] ifetch_addr;
    logic            ifetch_rsp_valid;
    logic [31:0]     ifetch_rsp_data;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic            dec_is_mem;
    logic            dec_is_ebreak;
    logic            exec_wb_en;
    logic [XLEN-1:0] exec_next_pc;
    logic            dmem_req_valid;
    logic            dmem_req_ready;
    logic            dmem_rsp_valid;
    logic            reg_we;
    logic            commit;
    logic [XLEN-1:0] instret;
    logic            halted;
    logic [1:0]      halt_code;

    int n_checks = 0;
    int n_fail   = 0;

    core_step_fsm #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .ifetch_req_valid (ifetch_req_valid),
        .ifetch_req_ready (ifetch_req_ready),
        .ifetch_addr      (ifetch_addr),
        .ifetch_rsp_valid (ifetch_rsp_valid),
        .ifetch_rsp_data  (ifetch_rsp_data),
        .instr            (instr),
        .pc               (pc),
        .dec_is_mem       (dec_is_mem),
        .dec_is_ebreak    (dec_is_ebreak),
        .exec_wb_en       (exec_wb_en),
        .exec_next_pc     (exec_next_pc),
        .dmem_req_valid   (dmem_req_valid),
        .dmem_req_ready   (dmem_req_ready),
        .dmem_rsp_valid   (dmem_rsp_valid),
        .reg_we           (reg_we),
        .commit           (commit),
        .instret          (instret),
        .halted           (halted),
        .halt_code        (halt_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Move to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs follow freshly driven inputs.
    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        ifetch_req_ready = 1'b0;
        ifetch_rsp_valid = 1'b0;
        ifetch_rsp_data  = '0;
        dec_is_mem       = 1'b0;
        dec_is_ebreak    = 1'b0;
        exec_wb_en       = 1'b0;
        exec_next_pc     = '0;
        dmem_req_ready   = 1'b0;
        dmem_rsp_valid   = 1'b0;
    endtask

    // Apply one reset edge, then release rst within the following cycle.
    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();

        // ---------------- reset state ----------------
        tick();
        check("rst_ifetch_valid", ifetch_req_valid, 0);
        check("rst_dmem_valid",   dmem_req_valid,   0);
        check("rst_reg_we",       reg_we,           0);
        check("rst_commit",       commit,           0);
        check("rst_pc",           pc,               RESET_PC);
        check("rst_instr",        instr,            0);
        check("rst_instret",      instret,          0);
        check("rst_halted",       halted,           0);
        check("rst_halt_code",    halt_code,        0);
        rst = 1'b0;
        settle();
        check("post_rst_ifetch_valid", ifetch_req_valid, 1);
        check("post_rst_ifetch_addr",  ifetch_addr,      RESET_PC);

        // ---------------- zero-wait addi ----------------
        ifetch_req_ready = 1'b1;
        tick();                                   // FETCH_WAIT
        ifetch_req_ready = 1'b0;
        ifetch_rsp_valid = 1'b1;
        ifetch_rsp_data  = 32'h0010_0093;
        settle();
        check("addi_fw_ifetch_valid", ifetch_req_valid, 0);
        check("addi_fw_commit",       commit,           0);
        tick();                                   // EXEC
        ifetch_rsp_valid = 1'b0;
        exec_wb_en       = 1'b1;
        exec_next_pc     = 64'h8000_0004;
        settle();
        check("addi_ex_instr",  instr,  32'h0010_0093);
        check("addi_ex_commit", commit, 0);
        check("addi_ex_reg_we", reg_we, 0);
        tick();                                   // WB, cycle 4
        check("addi_wb_reg_we",  reg_we,  1);
        check("addi_wb_commit",  commit,  1);
        check("addi_wb_instret", instret, 0);
        tick();                                   // FETCH_REQ
        check("addi_pc",           pc,               64'h8000_0004);
        check("addi_instret",      instret,          1);
        check("addi_after_commit", commit,           0);
        check("addi_after_reg_we", reg_we,           0);
        check("addi_next_valid",   ifetch_req_valid, 1);
        check("addi_next_addr",    ifetch_addr,      64'h8000_0004);

        // ---------------- load with stalled data port ----------------
        ifetch_req_ready = 1'b1;
        tick();                                   // FETCH_WAIT
        ifetch_req_ready = 1'b0;
        ifetch_rsp_valid = 1'b1;
        ifetch_rsp_data  = 32'h0000_2103;
        tick();                                   // EXEC
        ifetch_rsp_valid = 1'b0;
        dec_is_mem       = 1'b1;
        exec_wb_en       = 1'b1;
        exec_next_pc     = 64'h8000_0008;
        settle();
        check("ld_ex_dmem_valid", dmem_req_valid, 0);
        tick();                                   // MEM_REQ
        for (int i = 0; i < 4; i++) begin
            dmem_req_ready = (i == 3);
            settle();
            check("ld_memreq_valid",  dmem_req_valid, 1);
            check("ld_memreq_commit", commit,         0);
            tick();
        end
        dmem_req_ready = 1'b0;                    // MEM_WAIT, 1st cycle
        settle();
        check("ld_memwait_valid", dmem_req_valid, 0);
        check("ld_memwait_commit", commit, 0);
        tick();                                   // MEM_WAIT, 2nd cycle
        dmem_rsp_valid = 1'b1;
        settle();
        check("ld_rsp_commit", commit, 0);
        tick();                                   // WB
        dmem_rsp_valid = 1'b0;
        settle();
        check("ld_wb_commit", commit, 1);
        check("ld_wb_reg_we", reg_we, 1);
        tick();                                   // FETCH_REQ
        check("ld_instret", instret, 2);
        check("ld_pc",      pc,      64'h8000_0008);
        check("ld_commit",  commit,  0);

        // ---------------- misaligned next pc ----------------
        dec_is_mem       = 1'b0;
        ifetch_req_ready = 1'b1;
        tick();                                   // FETCH_WAIT
        ifetch_req_ready = 1'b0;
        ifetch_rsp_valid = 1'b1;
        ifetch_rsp_data  = 32'h0FC0_006F;
        tick();                                   // EXEC
        ifetch_rsp_valid = 1'b0;
        exec_wb_en       = 1'b1;
        exec_next_pc     = 64'h8000_0102;
        tick();                                   // WB
        check("mis_wb_commit", commit, 1);
        tick();                                   // HALT
        check("mis_pc",        pc,        64'h8000_0102);
        check("mis_halted",    halted,    1);
        check("mis_halt_code", halt_code, 2);
        check("mis_instret",   instret,   3);
        ifetch_req_ready = 1'b1;
        ifetch_rsp_valid = 1'b1;
        ifetch_rsp_data  = 32'hDEAD_BEEF;
        dmem_rsp_valid   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt_ifetch_valid", ifetch_req_valid, 0);
            check("halt_commit",       commit,           0);
            check("halt_reg_we",       reg_we,           0);
        end
        check("halt_pc_frozen",      pc,        64'h8000_0102);
        check("halt_instr_frozen",   instr,     32'h0FC0_006F);
        check("halt_instret_frozen", instret,   3);
        check("halt_code_frozen",    halt_code, 2);
        clear_inputs();
        do_reset();
        check("rst1_halted",       halted,           0);
        check("rst1_halt_code",    halt_code,        0);
        check("rst1_pc",           pc,               RESET_PC);
        check("rst1_instret",      instret,          0);
        check("rst1_ifetch_valid", ifetch_req_valid, 1);

        // ---------------- ebreak (with dec_is_mem also set) ----------------
        ifetch_req_ready = 1'b1;
        tick();                                   // FETCH_WAIT
        ifetch_req_ready = 1'b0;
        ifetch_rsp_valid = 1'b1;
        ifetch_rsp_data  = 32'h0010_0073;
        tick();                                   // EXEC
        ifetch_rsp_valid = 1'b0;
        dec_is_ebreak    = 1'b1;
        dec_is_mem       = 1'b1;
        exec_wb_en       = 1'b1;
        settle();
        check("eb_ex_commit", commit, 1);
        check("eb_ex_reg_we", reg_we, 0);
        check("eb_ex_halted", halted, 0);
        tick();                                   // HALT
        check("eb_halted",     halted,         1);
        check("eb_halt_code",  halt_code,      1);
        check("eb_instret",    instret,        1);
        check("eb_pc",         pc,             RESET_PC);
        check("eb_dmem_valid", dmem_req_valid, 0);
        check("eb_commit",     commit,         0);
        clear_inputs();
        do_reset();
        check("rst2_ifetch_valid", ifetch_req_valid, 1);
        check("rst2_ifetch_addr",  ifetch_addr,      RESET_PC);
        check("rst2_instret",      instret,          0);
        check("rst2_halted",       halted,           0);

        // ---------------- stray fetch response, reset in MEM_WAIT ----------------
        ifetch_rsp_valid = 1'b1;                  // not in FETCH_WAIT: ignored
        ifetch_rsp_data  = 32'hDEAD_BEEF;
        tick();
        ifetch_rsp_valid = 1'b0;
        settle();
        check("stray_rsp_instr", instr, 0);
        ifetch_req_ready = 1'b1;
        tick();                                   // FETCH_WAIT
        ifetch_req_ready = 1'b0;
        ifetch_rsp_valid = 1'b1;
        ifetch_rsp_data  = 32'h0000_2183;
        tick();                                   // EXEC
        ifetch_rsp_valid = 1'b0;
        dec_is_mem       = 1'b1;
        exec_wb_en       = 1'b1;
        exec_next_pc     = 64'h8000_0004;
        tick();                                   // MEM_REQ
        dmem_req_ready = 1'b1;
        tick();                                   // MEM_WAIT
        dmem_req_ready = 1'b0;
        rst            = 1'b1;
        settle();
        check("rmw_rst_reg_we", reg_we, 0);
        check("rmw_rst_commit", commit, 0);
        tick();                                   // reset edge -> FETCH_REQ
        rst            = 1'b0;
        dmem_rsp_valid = 1'b1;                    // late response for old request
        settle();
        check("rmw_reg_we",       reg_we,           0);
        check("rmw_commit",       commit,           0);
        check("rmw_ifetch_valid", ifetch_req_valid, 1);
        check("rmw_ifetch_addr",  ifetch_addr,      RESET_PC);
        check("rmw_dmem_valid",   dmem_req_valid,   0);
        check("rmw_instr",        instr,            0);
        tick();
        dmem_rsp_valid = 1'b0;
        settle();
        check("rmw2_commit",       commit,           0);
        check("rmw2_reg_we",       reg_we,           0);
        check("rmw2_instret",      instret,          0);
        check("rmw2_ifetch_valid", ifetch_req_valid, 1);
        check("rmw2_pc",           pc,               RESET_PC);

        // ---------------- fetch timeout ----------------
        clear_inputs();
        do_reset();                               // stall cycle 1
        for (int i = 1; i < int'(TIMEOUT); i++) begin
            tick();                               // stall cycles 2..TIMEOUT
            check("to_ifetch_valid_held", ifetch_req_valid, 1);
        end
        check("to_not_yet_halted", halted, 0);
        tick();
        check("to_halted",       halted,           1);
        check("to_halt_code",    halt_code,        3);
        check("to_instret",      instret,          0);
        check("to_ifetch_valid", ifetch_req_valid, 0);
        check("to_commit",       commit,           0);
        check("to_pc",           pc,               RESET_PC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/core_step_fsm.md
CORE_STEP_FSM -- requirements
Module: core_step_fsm

Interface
REQ-001 Parameter: XLEN, default 64, width of PC, next-PC and retire counter.
REQ-002 Parameter: RESET_PC, default 64'h8000_0000, PC value loaded by reset.
REQ-003 Parameter: TIMEOUT, default 256, maximum cycles spent in any single REQ or WAIT state before abort.
REQ-004 Port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 Port: rst  in  1  synchronous, active-high reset.
REQ-006 Port: ifetch_req_valid  out  1  instruction fetch request.
REQ-007 Port: ifetch_req_ready  in  1  fetch request accepted.
REQ-008 Port: ifetch_addr  out  XLEN  fetch address; equals pc.
REQ-009 Port: ifetch_rsp_valid  in  1  fetch data valid.
REQ-010 Port: ifetch_rsp_data  in  32  fetched instruction.
REQ-011 Port: instr  out  32  registered instruction, fed to decoder and datapath.
REQ-012 Port: pc  out  XLEN  architectural PC.
REQ-013 Port: dec_is_mem, dec_is_ebreak, exec_wb_en  in  1 each  decoder/datapath flags for instr.
REQ-014 Port: exec_next_pc  in  XLEN  next PC from the datapath next-PC mux.
REQ-015 Port: dmem_req_valid  out  1 ; dmem_req_ready  in  1 ; dmem_rsp_valid  in  1  data memory handshake.
REQ-016 Port: reg_we  out  1  register-file write enable, one-cycle pulse.
REQ-017 Port: commit  out  1  retire pulse.
REQ-018 Port: instret  out  XLEN  retired-instruction count.
REQ-019 Port: halted  out  1 ; halt_code  out  2  (1 ebreak, 2 misaligned PC, 3 timeout, 0 running).

Function
REQ-020 FSM states SHALL be FETCH_REQ, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, HALT.
REQ-021 FETCH_REQ: ifetch_req_valid=1, ifetch_addr stable; on valid&ready -> FETCH_WAIT next cycle; valid never drops before acceptance.
REQ-022 FETCH_WAIT: on ifetch_rsp_valid, instr <= ifetch_rsp_data, -> EXEC; ifetch_rsp_valid in any other state SHALL be ignored.
REQ-023 EXEC (exactly one cycle): dec_is_ebreak -> HALT with code 1, commit=1, instret+1; else dec_is_mem -> MEM_REQ; else -> WB; ebreak has priority over dec_is_mem.
REQ-024 MEM_REQ: dmem_req_valid=1 until dmem_req_ready -> MEM_WAIT; MEM_WAIT: dmem_rsp_valid -> WB.
REQ-025 WB (exactly one cycle): reg_we=exec_wb_en, commit=1, instret+1, pc <= exec_next_pc.
REQ-026 WB: if exec_next_pc[1:0]!=0, pc is still loaded, instruction still retires, -> HALT with code 2; else -> FETCH_REQ.
REQ-027 Non-memory instruction latency SHALL be 4 cycles from FETCH_REQ entry with zero-wait memory (REQ, WAIT, EXEC, WB).
REQ-028 A per-state wait counter SHALL clear on every state change; reaching TIMEOUT in FETCH_REQ, FETCH_WAIT, MEM_REQ or MEM_WAIT -> HALT with code 3, no commit.
REQ-029 HALT is absorbing until rst: all valids, reg_we and commit 0; pc, instr, instret frozen.
REQ-030 instret SHALL wrap from 2^XLEN-1 to 0 with no other effect.
REQ-031 reg_we and commit SHALL be 0 in every state except WB (commit also in EXEC on ebreak).

Reset
REQ-032 rst asserted at a clock edge SHALL force next state FETCH_REQ, pc=RESET_PC, instr=0, instret=0, halted=0, halt_code=0, wait counter=0, from any state including mid-handshake and HALT.
REQ-033 During the rst cycle and the cycle following, outputs SHALL be: ifetch_req_valid=0 during rst, then 1 with ifetch_addr=RESET_PC; dmem_req_valid, reg_we, commit=0.
REQ-034 A response arriving after rst for a pre-reset request SHALL be dropped.

Verification
REQ-035 Zero-wait fetch of addi, exec_next_pc=pc+4, exec_wb_en=1 -> reg_we and commit pulse in cycle 4, pc=0x8000_0004, instret=1.
REQ-036 Load with dmem_req_ready delayed 3 cycles and dmem_rsp_valid 2 cycles later -> single commit, instret=1, dmem_req_valid held 4 cycles continuously.
REQ-037 exec_next_pc=0x8000_0102 in WB -> commit, pc=0x8000_0102, halted=1, halt_code=2, no further ifetch_req_valid.
REQ-038 ifetch_req_ready held 0 for TIMEOUT cycles -> halted=1, halt_code=3, instret unchanged.
REQ-039 ebreak instruction -> commit in EXEC, halted=1, halt_code=1; rst then -> fetch restarts at 0x8000_0000, instret=0.
REQ-040 rst asserted in MEM_WAIT, dmem_rsp_valid pulsed next cycle -> no reg_we, no commit, fetch at RESET_PC.
